// File: rtl/pattern_sequence_generator_if.sv
// Start/Busy/Done handshake and serial output bundle for the pattern generator.
interface pattern_sequence_generator_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             Start;
    logic             Abort;
    logic [PAT_W-1:0] Pattern;
    logic [CNT_W-1:0] Repeat;
    logic [GAP_W-1:0] Gap;
    logic             Dout;
    logic             Dvalid;
    logic             Frame;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Abort, Pattern, Repeat, Gap,
        input  Dout, Dvalid, Frame, Busy, Done
    );

    modport slave (
        input  Start, Abort, Pattern, Repeat, Gap,
        output Dout, Dvalid, Frame, Busy, Done
    );
endinterface

// File: rtl/pattern_sequence_generator.sv
// Bit-serial pattern transmitter: sends a latched pattern MSB-first a number of
// times with an optional idle gap between repetitions.
//
//   state  | meaning
//   IDLE   | waiting for Start
//   SEND   | shifting pattern bits out, one per cycle
//   GAP    | idle cycles between repetitions
//   DONE   | one-cycle completion pulse
module pattern_sequence_generator #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic Clock,
    input  logic Reset,
    pattern_sequence_generator_if.slave bus
);
    localparam int BIT_W = $clog2(PAT_W);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pat_d   = pat_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;

        if (bus.Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        if (bus.Repeat == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SEND;
                            pat_d   = bus.Pattern;
                            shift_d = bus.Pattern;
                            rep_d   = bus.Repeat;
                            gap_d   = bus.Gap;
                            bit_d   = '0;
                        end
                    end
                end
                S_SEND: begin
                    if (bit_q == BIT_W'(PAT_W - 1)) begin
                        rep_d = rep_q - CNT_W'(1);
                        if (rep_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else if (gap_q == '0) begin
                            shift_d = pat_q;
                            bit_d   = '0;
                        end else begin
                            state_d = S_GAP;
                            gcnt_d  = gap_q;
                        end
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gcnt_q == GAP_W'(1)) begin
                        state_d = S_SEND;
                        shift_d = pat_q;
                        bit_d   = '0;
                    end
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered copies of what the next state will present.
        dvalid_d = (state_d == S_SEND);
        dout_d   = dvalid_d & shift_d[PAT_W-1];
        frame_d  = dvalid_d & (bit_d == '0);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            pat_q    <= '0;
            bit_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            pat_q    <= pat_d;
            bit_q    <= bit_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.Dout   = dout_q;
    assign bus.Dvalid = dvalid_q;
    assign bus.Frame  = frame_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
endmodule

// File: tb/tb_pattern_sequence_generator.sv
// Directed bench for pattern_sequence_generator with hand-computed per-cycle waveforms.
module tb_pattern_sequence_generator;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    pattern_sequence_generator_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus ();

    pattern_sequence_generator #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic d, input logic v,
                              input logic f, input logic b, input logic dn);
        check_val({tag, " dout"},   32'(bus.Dout),   32'(d));
        check_val({tag, " dvalid"}, 32'(bus.Dvalid), 32'(v));
        check_val({tag, " frame"},  32'(bus.Frame),  32'(f));
        check_val({tag, " busy"},   32'(bus.Busy),   32'(b));
        check_val({tag, " done"},   32'(bus.Done),   32'(dn));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Waveforms are 16-bit, leftmost bit = cycle 1 after Start is sampled.
    task automatic run_case(input string tag, input logic [3:0] pat, input logic [7:0] rep,
                            input logic [3:0] gap, input int poke,
                            input logic [15:0] e_dout, input logic [15:0] e_dv,
                            input logic [15:0] e_fr, input logic [15:0] e_busy,
                            input logic [15:0] e_done);
        bus.Pattern = pat;
        bus.Repeat  = rep;
        bus.Gap     = gap;
        bus.Start   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin
                bus.Start   = 1'b0;
                bus.Pattern = ~pat;
                bus.Repeat  = 8'd5;
                bus.Gap     = 4'd7;
            end
            if (poke != 0 && k == poke) bus.Start = 1'b1;
            if (poke != 0 && k == poke + 1) bus.Start = 1'b0;
            check_outs($sformatf("%s c%0d", tag, k), e_dout[16-k], e_dv[16-k],
                       e_fr[16-k], e_busy[16-k], e_done[16-k]);
        end
        bus.Start = 1'b0;
    endtask

    initial begin
        bus.Start   = 1'b0;
        bus.Abort   = 1'b0;
        bus.Pattern = '0;
        bus.Repeat  = '0;
        bus.Gap     = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        tick();

        // Single repetition; Start during DONE (cycle 5) must be ignored.
        run_case("r1", 4'b1101, 8'd1, 4'd0, 5,
                 16'b1101_0000_0000_0000, 16'b1111_0000_0000_0000,
                 16'b1000_0000_0000_0000, 16'b1111_1000_0000_0000,
                 16'b0000_1000_0000_0000);
        // Back-to-back repetitions; Start while busy ignored.
        run_case("r3", 4'b1101, 8'd3, 4'd0, 3,
                 16'b1101_1101_1101_0000, 16'b1111_1111_1111_0000,
                 16'b1000_1000_1000_0000, 16'b1111_1111_1111_1000,
                 16'b0000_0000_0000_1000);
        // Gap of three idle cycles between repetitions.
        run_case("gap3", 4'b1011, 8'd2, 4'd3, 6,
                 16'b1011_0001_0110_0000, 16'b1111_0001_1110_0000,
                 16'b1000_0001_0000_0000, 16'b1111_1111_1111_0000,
                 16'b0000_0000_0001_0000);
        // Zero repetitions: immediate Done, no data.
        run_case("r0", 4'b1111, 8'd0, 4'd0, 0,
                 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000);

        // Abort on 2nd bit of 2nd repetition, then restart next cycle.
        bus.Pattern = 4'b1101;
        bus.Repeat  = 8'd2;
        bus.Gap     = 4'd0;
        bus.Start   = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (5) tick();
        check_outs("abort c6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.Abort = 1'b1;
        tick();
        bus.Abort = 1'b0;
        check_outs("abort c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.Pattern = 4'b0110;
        bus.Repeat  = 8'd1;
        bus.Start   = 1'b1;
        tick();
        bus.Start = 1'b0;
        check_outs("restart c1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("restart c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check_outs("restart done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Abort and Start together in IDLE: nothing starts.
        bus.Abort = 1'b1;
        bus.Start = 1'b1;
        tick();
        bus.Abort = 1'b0;
        bus.Start = 1'b0;
        check_outs("abort+start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("abort+start nx", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-SEND.
        bus.Pattern = 4'b1111;
        bus.Repeat  = 8'd3;
        bus.Start   = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        check_outs("pre-rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        check_outs("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        Reset = 1'b0;
        tick();
        check_outs("post-rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start accepted normally after reset.
        run_case("after rst", 4'b0111, 8'd1, 4'd0, 0,
                 16'b0111_0000_0000_0000, 16'b1111_0000_0000_0000,
                 16'b1000_0000_0000_0000, 16'b1111_1000_0000_0000,
                 16'b0000_1000_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pattern_sequence_generator.md
Name: pattern_sequence_generator

Overview:
Bit-serial pattern transmitter. It loads a PAT_W-bit pattern and shifts it out MSB-first a programmable number of times, with an optional idle gap between repetitions. It is the stimulus/transmit side for the team's serial sequence detectors, and it drives a Din-style single-bit line plus a qualifying valid. Control is a Start/Busy/Done handshake with Abort.

Parameters:
PAT_W, 4, pattern length in bits (≥2)
CNT_W, 8, width of repetition count
GAP_W, 4, width of inter-repetition gap count

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Abort  input  1  synchronous cancel; highest priority after Reset
Pattern  input  PAT_W  pattern to send, latched on accepted Start
Repeat  input  CNT_W  number of repetitions, latched on accepted Start
Gap  input  GAP_W  idle cycles between repetitions, latched on accepted Start
Dout  output  1  serial data, registered
Dvalid  output  1  Dout carries a pattern bit, registered
Frame  output  1  high with the first (MSB) bit of each repetition
Busy  output  1  high from the cycle after an accepted Start through the DONE cycle
Done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async): state IDLE; Dout, Dvalid, Frame, Busy, Done = 0; internal shift register, bit counter, repetition counter and gap counter = 0.
- Reset is checked first, then Abort; otherwise the state advances.
- FSM states: IDLE, SEND, GAP, DONE. All outputs are registered and are functions of the state/counter registers.
- IDLE:
  - Start=1 and Repeat≠0: latch Pattern, Repeat, Gap, then go to SEND. The first bit appears in the cycle after Start is sampled (latency 1).
  - Start=1 and Repeat=0: go to DONE. No bits are sent and Done pulses next cycle.
  - Start=0: stay in IDLE.
- SEND:
  - Dvalid=1; Dout = current MSB of the shift register; shift left each cycle.
  - Frame=1 only on bit index 0 of each repetition.
  - A repetition takes exactly PAT_W cycles.
- After the last bit of a repetition, decrement the remaining count:
  - remaining=0: go to DONE.
  - Gap=0: reload the shift register from the latched pattern and stay in SEND. Repetitions run back-to-back with no bubble.
  - Otherwise: go to GAP.
- GAP: Dvalid=0, Dout=0, Frame=0 for exactly Gap cycles. Then reload the pattern and go to SEND.
- DONE: Done=1 and Busy=1 for one cycle; Dvalid=0. Return to IDLE. Start sampled during DONE is ignored.
- Start while Busy: ignored. Input changes on Pattern, Repeat or Gap while Busy have no effect.
- Abort=1 in any state: next cycle is IDLE with Dvalid=0, Busy=0, Done=0, Frame=0. No Done pulse. A partial pattern is truncated.
- Abort and Start in the same IDLE cycle: Abort wins and nothing starts.
- Total Busy length for R≥1 repetitions = R·PAT_W + (R−1)·Gap + 1 cycles (the final +1 is DONE).
- Counters:
  - Bit counter: ceil(log2(PAT_W)) bits, no wrap beyond PAT_W−1.
  - Repetition counter: CNT_W bits; Repeat = 2^CNT_W−1 (255 at default) must complete without overflow.
- Reset mid-operation: outputs drop asynchronously to 0 and the block returns to IDLE. The latched pattern is discarded.

Test Plan:
- Pattern=4'b1101, Repeat=1, Gap=0, single Start pulse → Dout=1,1,0,1 on cycles 1–4 with Dvalid=1 and Frame=1 only on cycle 1; Done pulse on cycle 5; Busy high cycles 1–5.
- Pattern=4'b1101, Repeat=3, Gap=0 → contiguous stream 110111011101 with Dvalid=1 for 12 cycles; Frame on cycles 1, 5, 9; Done on cycle 13.
- Pattern=4'b1011, Repeat=2, Gap=3 → 1011, then 3 cycles Dvalid=0/Dout=0, then 1011; Done on cycle 12; Busy for 12 cycles.
- Repeat=0 with Start → Dvalid never asserts; Done=1 on cycle 1; back in IDLE on cycle 2.
- Repeat=2, Abort asserted on the 2nd bit of the 2nd repetition → next cycle Dvalid=0, Busy=0, no Done. A new Start is accepted the following cycle.
- Reset pulsed asynchronously mid-SEND (between clock edges) → all outputs 0 immediately. Start asserted in the same cycle as a DONE state is ignored. A Start issued in IDLE afterwards is accepted normally.
